// File: rtl/calc_dist_mc.sv
`default_nettype none
// ============================================================================
// Module   : calc_dist_mc
// Purpose  : Multi-channel echo-to-distance calculator.
//            dist = (N_echo / DIV_K) * VEL in unsigned Q-format fixed point.
//            One shared restoring bit-serial divider and one multiplier serve
//            CH channels. Requests are latched per channel and served in
//            round-robin order, with saturation and overflow flagging.
// Ports    : clk      - system clock, rising edge
//            rst_n    - synchronous active-low reset
//            strt     - per-channel start strobes (CH bits)
//            N_echo   - packed echo counts, channel i at [i*N +: N]
//            dist_out - distance result (Q format)
//            dist_ch  - channel index of dist_out
//            dist_rdy - one-cycle valid strobe for dist_out/dist_ch/dist_ovf
//            dist_ovf - result saturated (quotient or product overflow)
//            busy     - datapath active or a request pending
// Revision : 1.0 - initial release
// ============================================================================
module calc_dist_mc #(
   parameter int unsigned N      = 32,
   parameter int unsigned Q      = 15,
   parameter int unsigned CH     = 4,
   parameter logic [N-1:0] DIV_K = 32'h0131_2D00,
   parameter logic [N-1:0] VEL   = 32'h00AA_0000,
   localparam int unsigned CHW   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH-1:0]   strt,
   input  logic [CH*N-1:0] N_echo,
   output logic [N-1:0]    dist_out,
   output logic [CHW-1:0]  dist_ch,
   output logic            dist_rdy,
   output logic            dist_ovf,
   output logic            busy
);

   localparam int unsigned DW = N + Q;          // dividend / quotient width
   localparam int unsigned CW = $clog2(DW);     // divide step counter width

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_MUL  = 2'd2
   } state_t;

   state_t         state;
   logic [CH-1:0]  pending;
   logic [N-1:0]   echo_reg [CH];
   logic [CHW-1:0] rr_ptr;
   logic [CHW-1:0] cur_ch;
   // Dividend bits shift out of the top while quotient bits shift in at the
   // bottom; after DW steps the register holds the full quotient.
   logic [DW-1:0]  dvd;
   logic [N-1:0]   rem;
   logic [CW-1:0]  cnt;

   // ------------------------------------------------------------------------
   // Round-robin arbiter: lowest pending index at or above rr_ptr, wrapping.
   // ------------------------------------------------------------------------
   logic [CHW-1:0] grant;
   logic [CHW-1:0] rr_next;
   logic           found;
   logic [CHW:0]   scan;

   always_comb begin
      grant = '0;
      found = 1'b0;
      scan  = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         scan = {1'b0, rr_ptr} + (CHW+1)'(k);
         if (scan >= (CHW+1)'(CH)) begin
            scan = scan - (CHW+1)'(CH);
         end
         if (!found && pending[scan[CHW-1:0]]) begin
            found = 1'b1;
            grant = scan[CHW-1:0];
         end
      end
   end

   always_comb begin
      rr_next = '0;
      if ({1'b0, grant} != (CHW+1)'(CH - 1)) begin
         rr_next = grant + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Restoring divide step. The remainder is always below DIV_K, so the
   // N-bit difference is exact whenever the subtraction is taken.
   // ------------------------------------------------------------------------
   logic [N:0]   rem_sh;
   logic [N-1:0] rem_sub;
   logic         qbit;

   assign rem_sh  = {rem, dvd[DW-1]};
   assign rem_sub = rem_sh[N-1:0] - DIV_K;
   assign qbit    = (rem_sh >= {1'b0, DIV_K});

   // ------------------------------------------------------------------------
   // Saturating quotient and product.
   // ------------------------------------------------------------------------
   logic           div_ovf;
   logic [N-1:0]   q_sat;
   logic [2*N-1:0] prod;
   logic [2*N-1:0] prod_sh;
   logic           mul_ovf;
   logic [N-1:0]   result;

   assign div_ovf = |dvd[DW-1:N];
   assign q_sat   = div_ovf ? {N{1'b1}} : dvd[N-1:0];
   assign prod    = {{N{1'b0}}, q_sat} * {{N{1'b0}}, VEL};
   assign prod_sh = prod >> Q;
   assign mul_ovf = |prod_sh[2*N-1:N];
   assign result  = (div_ovf || mul_ovf) ? {N{1'b1}} : prod_sh[N-1:0];

   assign busy = (state != S_IDLE) || (|pending);

   // ------------------------------------------------------------------------
   // Control FSM, request latch and registered outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pending  <= '0;
         rr_ptr   <= '0;
         cur_ch   <= '0;
         dvd      <= '0;
         rem      <= '0;
         cnt      <= '0;
         dist_out <= '0;
         dist_ch  <= '0;
         dist_ovf <= 1'b0;
         dist_rdy <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            echo_reg[i] <= '0;
         end
      end else begin
         dist_rdy <= 1'b0;

         case (state)
            S_IDLE: begin
               if (found) begin
                  state           <= S_DIV;
                  cur_ch          <= grant;
                  rr_ptr          <= rr_next;
                  dvd             <= {echo_reg[grant], {Q{1'b0}}};
                  rem             <= '0;
                  cnt             <= '0;
                  pending[grant]  <= 1'b0;
               end
            end
            S_DIV: begin
               dvd <= {dvd[DW-2:0], qbit};
               rem <= qbit ? rem_sub : rem_sh[N-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(DW - 1)) begin
                  state <= S_MUL;
               end
            end
            S_MUL: begin
               dist_out <= result;
               dist_ch  <= cur_ch;
               dist_ovf <= div_ovf || mul_ovf;
               dist_rdy <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         // Placed after the grant so a strobe on the channel being granted
         // re-arms it; the grant has already captured the previous echo.
         for (int i = 0; i < CH; i++) begin
            if (strt[i]) begin
               pending[i]  <= 1'b1;
               echo_reg[i] <= N_echo[i*N +: N];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_dist_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_calc_dist_mc
// Purpose  : Scoreboard bench for calc_dist_mc. Stimulus pushes expected
//            results (value, channel, arrival edge) into queues; monitors pop
//            and compare on every dist_rdy. A second instance uses DIV_K=1 to
//            reach the quotient and product overflow paths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_dist_mc;

   localparam int          N      = 32;
   localparam int          Q      = 15;
   localparam int          CH     = 4;
   localparam int          LAT    = N + Q + 2;
   localparam logic [31:0] DIV_K  = 32'h0131_2D00;
   localparam logic [31:0] VEL    = 32'h00AA_0000;
   localparam logic [31:0] K1_DIV = 32'h0000_0001;
   localparam logic [31:0] K1_VEL = 32'h0001_8000;   // 3.0

   typedef struct {
      int          ch;
      logic [31:0] out;
      logic        ovf;
      longint      cyc;
   } exp_t;

   logic            clk    = 1'b0;
   logic            rst_n  = 1'b0;
   logic [CH-1:0]   strt   = '0;
   logic [CH*N-1:0] n_echo = '0;
   logic [N-1:0]    dist_out;
   logic [1:0]      dist_ch;
   logic            dist_rdy;
   logic            dist_ovf;
   logic            busy;

   logic [1:0]      strt_k1 = '0;
   logic [2*N-1:0]  echo_k1 = '0;
   logic [N-1:0]    dist_out_k1;
   logic            dist_ch_k1;
   logic            dist_rdy_k1;
   logic            dist_ovf_k1;
   logic            busy_k1;

   longint cyc = 0;
   int     tests = 0;
   int     fails = 0;
   int     rdy_seen = 0;
   int     rr = 0;
   exp_t   sb[$];
   exp_t   sbk[$];

   calc_dist_mc #(.N(N), .Q(Q), .CH(CH), .DIV_K(DIV_K), .VEL(VEL)) dut (
      .clk(clk), .rst_n(rst_n), .strt(strt), .N_echo(n_echo),
      .dist_out(dist_out), .dist_ch(dist_ch), .dist_rdy(dist_rdy),
      .dist_ovf(dist_ovf), .busy(busy)
   );

   calc_dist_mc #(.N(N), .Q(Q), .CH(2), .DIV_K(K1_DIV), .VEL(K1_VEL)) dut_k1 (
      .clk(clk), .rst_n(rst_n), .strt(strt_k1), .N_echo(echo_k1),
      .dist_out(dist_out_k1), .dist_ch(dist_ch_k1), .dist_rdy(dist_rdy_k1),
      .dist_ovf(dist_ovf_k1), .busy(busy_k1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain wide arithmetic from the defining formula.
   function automatic void model(input logic [31:0] echo, input logic [31:0] divk,
                                 input logic [31:0] vel, output logic [31:0] out,
                                 output logic ovf);
      logic [127:0] q;
      logic [127:0] p;
      q   = ({96'd0, echo} << Q) / {96'd0, divk};
      ovf = 1'b0;
      if (q > 128'hFFFF_FFFF) begin
         q   = 128'hFFFF_FFFF;
         ovf = 1'b1;
      end
      p = (q * {96'd0, vel}) >> Q;
      if (p > 128'hFFFF_FFFF) ovf = 1'b1;
      out = ovf ? 32'hFFFF_FFFF : p[31:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic push_main(input int ch, input logic [31:0] ev, input longint t);
      exp_t        x;
      logic [31:0] o;
      logic        f;
      model(ev, DIV_K, VEL, o, f);
      x.ch = ch; x.out = o; x.ovf = f; x.cyc = t;
      sb.push_back(x);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((sb.size() != 0 || sbk.size() != 0 || busy || busy_k1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 1000) begin
         fails++;
         $display("FAIL %s_timeout: busy=%0b pending_results=%0d after %0d cycles, expected idle",
                  nm, busy, sb.size() + sbk.size(), n);
      end
   endtask

   task automatic pulse(input logic [CH-1:0] m, input logic [CH*N-1:0] v, output longint e);
      @(negedge clk);
      strt   = m;
      n_echo = v;
      e      = cyc + 1;
      @(negedge clk);
      strt   = '0;
   endtask

   // Strobe a mask in one cycle; expected order is round-robin from rr.
   task automatic round(input logic [CH-1:0] m, input logic [CH*N-1:0] v);
      longint e;
      int     k;
      int     last;
      pulse(m, v, e);
      k    = 0;
      last = rr;
      for (int i = 0; i < CH; i++) begin
         int c;
         c = (rr + i) % CH;
         if (m[c]) begin
            push_main(c, v[c*N +: N], e + longint'(LAT * (k + 1)));
            k++;
            last = c;
         end
      end
      rr = (last + 1) % CH;
      wait_idle("round");
   endtask

   task automatic round_k1(input logic [31:0] ev);
      longint      e;
      exp_t        x;
      logic [31:0] o;
      logic        f;
      @(negedge clk);
      strt_k1 = 2'b01;
      echo_k1 = {32'h0, ev};
      e       = cyc + 1;
      @(negedge clk);
      strt_k1 = '0;
      model(ev, K1_DIV, K1_VEL, o, f);
      x.ch = 0; x.out = o; x.ovf = f; x.cyc = e + LAT;
      sbk.push_back(x);
      wait_idle("k1");
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 4))
         0:       return 32'h0;
         1:       return DIV_K * $urandom_range(1, 8);
         2:       return $urandom_range(0, 65535);
         default: return $urandom;
      endcase
   endfunction

   // Monitor for the default instance.
   always @(negedge clk) begin
      exp_t e;
      if (dist_rdy) begin
         rdy_seen++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rdy: ch=%0d out=%h at edge %0d, expected no result",
                     dist_ch, dist_out, cyc);
         end else begin
            e = sb.pop_front();
            if (dist_ch !== 2'(e.ch) || dist_out !== e.out || dist_ovf !== e.ovf || cyc != e.cyc) begin
               fails++;
               $display("FAIL result: got ch=%0d out=%h ovf=%0b edge=%0d, expected ch=%0d out=%h ovf=%0b edge=%0d",
                        dist_ch, dist_out, dist_ovf, cyc, e.ch, e.out, e.ovf, e.cyc);
            end
         end
      end
   end

   // Monitor for the DIV_K=1 instance.
   always @(negedge clk) begin
      exp_t e;
      if (dist_rdy_k1) begin
         tests++;
         if (sbk.size() == 0) begin
            fails++;
            $display("FAIL k1_unexpected_rdy: out=%h at edge %0d, expected no result", dist_out_k1, cyc);
         end else begin
            e = sbk.pop_front();
            if (dist_ch_k1 !== 1'(e.ch) || dist_out_k1 !== e.out || dist_ovf_k1 !== e.ovf || cyc != e.cyc) begin
               fails++;
               $display("FAIL k1_result: got out=%h ovf=%0b edge=%0d, expected out=%h ovf=%0b edge=%0d",
                        dist_out_k1, dist_ovf_k1, cyc, e.out, e.ovf, e.cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH*N-1:0] v;
      logic [CH-1:0]   m;
      longint          e0;
      longint          e1;
      int              rdy_before;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dist_out", 64'(dist_out), 64'h0);
      chk("rst_dist_ch",  64'(dist_ch),  64'h0);
      chk("rst_dist_ovf", 64'(dist_ovf), 64'h0);
      chk("rst_dist_rdy", 64'(dist_rdy), 64'h0);
      chk("rst_busy",     64'(busy),     64'h0);
      rst_n = 1'b1;
      rr    = 0;

      // Directed values from the test plan, then rr back to 0.
      v = {$urandom, $urandom, $urandom, $urandom};
      v[0*N +: N] = 32'h0131_2D00;
      round(4'b0001, v);                       // ch0 -> 0x00AA0000
      v[2*N +: N] = 32'h0098_9680;
      round(4'b0100, v);                       // ch2 -> 0x00550000
      v[1*N +: N] = 32'h0;
      round(4'b0010, v);                       // ch1 -> 0
      round(4'b1000, v);                       // leaves rr at 0

      v = {32'h0262_5A00, 32'h0098_9680, 32'h0001_0000, 32'h0131_2D00};
      round(4'b1111, v);                       // order 0,1,2,3
      round(4'b0101, v);                       // order 0,2

      // Latest-wins: ch1 strobed twice while ch0 occupies the datapath.
      pulse(4'b0001, v, e0);
      push_main(0, v[0*N +: N], e0 + LAT);
      v[1*N +: N] = 32'h1234_5678;
      pulse(4'b0010, v, e1);
      v[1*N +: N] = 32'h0042_0000;
      pulse(4'b0010, v, e1);
      push_main(1, 32'h0042_0000, e0 + 2 * LAT);
      rr = 2;
      wait_idle("latest_wins");

      // Strobe on the same edge as the grant of that channel.
      @(negedge clk);
      strt = 4'b0001;
      n_echo[0*N +: N] = 32'h0131_2D00;
      e0 = cyc + 1;
      @(negedge clk);
      n_echo[0*N +: N] = 32'h0262_5A00;
      @(negedge clk);
      strt = '0;
      push_main(0, 32'h0131_2D00, e0 + LAT);
      push_main(0, 32'h0262_5A00, e0 + 2 * LAT);
      rr = 1;
      wait_idle("same_edge");

      // Re-strobe of the channel currently dividing.
      v[3*N +: N] = 32'h0500_0000;
      pulse(4'b1000, v, e0);
      push_main(3, 32'h0500_0000, e0 + LAT);
      repeat (10) @(negedge clk);
      v[3*N +: N] = 32'h0000_1234;
      pulse(4'b1000, v, e1);
      push_main(3, 32'h0000_1234, e0 + 2 * LAT);
      rr = 0;
      wait_idle("restrobe");

      // Randomised rounds.
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < CH; c++) v[c*N +: N] = rnd_val();
         m = 4'($urandom_range(1, 15));
         round(m, v);
      end

      // Reset in the middle of a divide aborts it.
      v[1*N +: N] = 32'h0131_2D00;
      pulse(4'b0010, v, e0);
      repeat (20) @(negedge clk);
      rdy_before = rdy_seen;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_dist_out", 64'(dist_out), 64'h0);
      chk("abort_dist_ch",  64'(dist_ch),  64'h0);
      chk("abort_dist_ovf", 64'(dist_ovf), 64'h0);
      chk("abort_busy",     64'(busy),     64'h0);
      repeat (60) @(negedge clk);
      chk("abort_no_rdy", 64'(rdy_seen - rdy_before), 64'h0);
      rr = 0;
      v[2*N +: N] = 32'h0098_9680;
      round(4'b0100, v);

      // DIV_K = 1 instance: no overflow, product overflow, quotient overflow.
      round_k1(32'h0000_8000);
      round_k1(32'h0001_0000);
      round_k1(32'h0002_0000);
      round_k1(32'h0000_0000);
      for (int r = 0; r < 6; r++) round_k1(32'($urandom_range(0, 32'h0004_0000)));

      repeat (5) @(negedge clk);
      chk("sb_drained", 64'(sb.size() + sbk.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/calc_dist_mc.md
Name: calc_dist_mc

Overview:
Multi-channel, parametrised successor to the single-channel echo-to-distance calculator. Computes dist = (N_echo / DIV_K) * VEL in unsigned Qm.Q fixed point for CH independent echo channels. Uses one shared bit-serial divider and one multiplier, with per-channel request latching, round-robin arbitration, saturation and overflow reporting. Sits between the per-sensor echo counters and the distance consumer/display logic.

Parameters:
N, 32, total word width of operands and result
Q, 15, fractional bits (all operands and the result are Q-format, unsigned)
CH, 4, number of echo channels (1..16)
DIV_K, 32'h0131_2D00, divisor constant (clock-to-time scale), Q format; must be nonzero
VEL, 32'h00AA_0000, velocity constant (340.0 in Q15), Q format
CHW, $clog2(CH) (min 1), channel index width (derived, not overridden)

Ports:
clk      in   1      system clock, all logic on rising edge
rst_n    in   1      synchronous active-low reset
strt     in   CH     per-channel start strobe, one-cycle pulse; bit i requests channel i
N_echo   in   CH*N   echo counts, channel i at bits [i*N +: N], sampled on strt[i]
dist_out out  N      distance result, Q format
dist_ch  out  CHW    channel index of dist_out
dist_rdy out  1      one-cycle valid strobe for dist_out/dist_ch/dist_ovf
dist_ovf out  1      result saturated (quotient or product overflow)
busy     out  1      datapath not IDLE or any request pending

Behaviour:
- Reset (rst_n=0 at an edge): pending, latched operands, dist_out, dist_ch, dist_ovf, dist_rdy and busy cleared to 0; FSM to IDLE; RR pointer to 0. Reset mid-computation aborts it with no dist_rdy.
- Request latch: on an edge with strt[i]=1, pending[i] <= 1 and echo_reg[i] <= N_echo[i]. If strt[i] arrives while pending[i]=1, echo_reg[i] is overwritten (latest wins; one result only). If the channel currently in DIV is re-strobed, the new request is queued normally.
- Arbiter: in IDLE, grant the lowest-index pending channel at or above rr_ptr (wrapping); rr_ptr <= grant+1 mod CH. A strt and a grant on the same channel at the same edge: the grant takes the old value and pending stays set with the new value.
- FSM: IDLE -> DIV (on any pending; load rem=0, dividend=echo_reg<<Q into N+Q-bit shift reg, clear pending[grant]) -> DIV for exactly N+Q edges (restoring, 1 quotient bit per edge, MSB first) -> MUL (1 edge) -> IDLE.
- Divide: q = floor((N_echo * 2^Q) / DIV_K), N+Q-bit internally. If q >= 2^N: q is saturated to all-ones and the ovf flag is set.
- Multiply: p = (q * VEL) >> Q, 2N-bit product truncated (no rounding). If p >= 2^N, or if the divide stage set ovf: dist_out = all-ones and dist_ovf = 1.
- Output: at the MUL edge, dist_out, dist_ch and dist_ovf are registered and dist_rdy <= 1. dist_rdy drops at the next edge. Outputs hold until the next result.
- Latency: strt edge to dist_rdy high is N+Q+2 edges (49 at defaults) when the datapath is idle. Back-to-back throughput is one result every N+Q+2 edges. Worst-case wait is CH*(N+Q+2).
- busy = (state != IDLE) | (|pending).
- No input back-pressure: strt is always accepted.

Test Plan:
- Defaults, strt[0] with N_echo[0]=32'h0131_2D00 -> after 49 edges dist_rdy=1 for one cycle, dist_out=32'h00AA_0000, dist_ch=0, dist_ovf=0.
- Defaults, ch2 N_echo=32'h0098_9680 -> dist_out=32'h0055_0000, dist_ch=2. Ch1 N_echo=0 -> dist_out=0, dist_ovf=0.
- strt=4'b1111 in one cycle with distinct echoes -> four dist_rdy pulses 49 edges apart, order ch0,1,2,3, each result correct. Then strt=4'b0101 with rr_ptr=0 -> order ch0, ch2.
- DIV_K=32'h0000_0001: N_echo=32'h0001_0000 -> q=2^31, no div ovf. N_echo=32'h0002_0000 -> dist_out=32'hFFFF_FFFF, dist_ovf=1.
- strt[1] twice (values A then B) before ch1 is granted -> a single result computed from B. Re-strobing the in-flight channel -> a second result follows.
- rst_n=0 for one edge mid-DIV -> no dist_rdy. Outputs, busy and pending are 0. A new strt afterwards completes in 49 edges.
